// File: rtl/mont_mul_if.sv
// Start/operand/result bundle for the bit-serial Montgomery multiplier.
// The master issues go with a, b, n; the slave returns p with busy/done status.
interface mont_mul_if #(
    parameter int WIDTH = 4096
);
    logic             go;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] p;
    logic             busy;
    logic             done;

    modport master (output go, a, b, n, input p, busy, done);
    modport slave  (input go, a, b, n, output p, busy, done);
endinterface

// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: p = a*b*R^-1 mod n, R = 2^WIDTH.
// One bit of a is consumed per LOOP cycle, LSB first.
// Optional feature macro: MONT_FINAL_SUB_EN
//   defined   : a final conditional-subtract state gives p < n, latency WIDTH+1.
//   undefined : the last LOOP cycle writes p directly, p < 2n, latency WIDTH;
//               the caller keeps n < 2^(WIDTH-1) so p fits in WIDTH bits.
module mont_mul #(
    parameter int WIDTH = 4096
) (
    input  logic      clk,
    input  logic      rst_n,
    mont_mul_if.slave bus
);
    localparam int ACC_W = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOP = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, b_q, n_q, p_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               start, last;

    // One Montgomery step: add b if the current a bit is set, make the sum even
    // by adding n, then halve. acc < 2n is preserved, so ACC_W never overflows.
    function automatic logic [ACC_W-1:0] mont_step(
        input logic [ACC_W-1:0] acc,
        input logic             a_bit,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] n
    );
        logic [ACC_W-1:0] t;
        t = acc + (a_bit ? {2'b00, b} : '0);
        if (t[0]) begin
            t = t + {2'b00, n};
        end
        return t >> 1;
    endfunction

`ifdef MONT_FINAL_SUB_EN
    // Bring acc from [0, 2n) into [0, n).
    function automatic logic [WIDTH-1:0] final_reduce(
        input logic [ACC_W-1:0] acc,
        input logic [WIDTH-1:0] n
    );
        logic [ACC_W-1:0] diff;
        diff = acc - {2'b00, n};
        return (acc >= {2'b00, n}) ? diff[WIDTH-1:0] : acc[WIDTH-1:0];
    endfunction
`endif

    assign start = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.go;
    assign last  = (cnt_q == CNT_LAST);
    assign acc_d = mont_step(acc_q, a_sh_q[0], b_q, n_q);
    assign bus.p = p_q;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; go is only honoured in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.go) begin
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                if (last) begin
`ifdef MONT_FINAL_SUB_EN
                    state_d = S_SUB;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_SUB:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        bus.busy = (state_q == S_LOOP) || (state_q == S_SUB);
        bus.done = (state_q == S_DONE);
    end

    // Datapath: operand latch on start, serial accumulation, result write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_q    <= '0;
            n_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            p_q    <= '0;
        end else if (start) begin
            a_sh_q <= bus.a;
            b_q    <= bus.b;
            n_q    <= bus.n;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (state_q == S_LOOP) begin
            acc_q  <= acc_d;
            a_sh_q <= a_sh_q >> 1;
            cnt_q  <= cnt_q + 1'b1;
`ifndef MONT_FINAL_SUB_EN
            if (last) begin
                p_q <= acc_d[WIDTH-1:0];
            end
`endif
        end else if (state_q == S_SUB) begin
`ifdef MONT_FINAL_SUB_EN
            p_q <= final_reduce(acc_q, n_q);
`endif
        end
    end
endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul at WIDTH=8 (R=256).
// Works with MONT_FINAL_SUB_EN defined (exact p, latency 9) or undefined
// (p congruent and < 2n, latency 8).
module tb_mont_mul;
    localparam int W = 8;
`ifdef MONT_FINAL_SUB_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mont_mul_if #(.WIDTH(W)) bus();
    mont_mul #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: the unique x in [0,n) with x*R == a*b (mod n).
    function automatic int ref_mont(input int a, input int b, input int n);
        for (int x = 0; x < n; x++) begin
            if (((x * (1 << W)) % n) == ((a * b) % n)) return x;
        end
        return 0;
    endfunction

    // Behavioural model: accepted go starts an LAT-cycle operation.
    logic m_busy, m_done;
    int   m_cnt, m_exp, m_n, m_p, m_pn;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
            m_p    <= 0;    m_pn   <= 1;    m_exp <= 0; m_n <= 1;
        end else if (bus.go && !m_busy) begin
            m_busy <= 1'b1; m_done <= 1'b0; m_cnt <= LAT;
            m_exp  <= ref_mont(int'(bus.a), int'(bus.b), int'(bus.n));
            m_n    <= int'(bus.n);
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_p <= m_exp; m_pn <= m_n;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("busy", longint'(bus.busy), longint'(m_busy));
            chk("done", longint'(bus.done), longint'(m_done));
`ifdef MONT_FINAL_SUB_EN
            chk("p", longint'(bus.p), longint'(m_p));
`else
            chk("p_mod_n", longint'(int'(bus.p) % m_pn), longint'(m_p));
            chk("p_lt_2n", longint'(int'(bus.p) < 2 * m_pn), 1);
`endif
        end
    end

    // Literal result check, relaxed to congruence in the lazy build.
    task automatic chk_p(input string name, input int v, input int n);
`ifdef MONT_FINAL_SUB_EN
        chk(name, longint'(bus.p), longint'(v));
`else
        chk(name, longint'(int'(bus.p) % n), longint'(v));
        chk({name, "_lt_2n"}, longint'(int'(bus.p) < 2 * n), 1);
`endif
    endtask

    // Issue one operation; optionally re-pulse go with other operands at cycle rp.
    task automatic run_op(input int a, input int b, input int n, input int rp, output int lat);
        @(negedge clk);
        bus.go = 1'b1; bus.a = W'(a); bus.b = W'(b); bus.n = W'(n);
        @(posedge clk); #1;
        chk("start_done_low", longint'(bus.done), 0);
        chk("start_busy_high", longint'(bus.busy), 1);
        bus.go = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.n = W'($urandom);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rp != 0 && lat == rp) begin
                bus.go = 1'b1; bus.a = W'(a ^ 3); bus.b = W'(b ^ 1);
            end else begin
                bus.go = 1'b0;
            end
        end
        if (!bus.done) chk("done_timeout", longint'(lat), LAT);
    endtask

    int lat;
    int rn, ra, rb;

    initial begin
        bus.go = 1'b0; bus.a = '0; bus.b = '0; bus.n = '0;
        #12;
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_p",    longint'(bus.p), 0);
        @(negedge clk); #2; rst_n = 1'b1;
        cmp_en = 1'b1;

        // Basic product and latency
        run_op(5, 7, 13, 0, lat);
        chk("t1_latency", longint'(lat), LAT);
        chk_p("t1_p", 1, 13);

        // Domain entry and exit
        run_op(5, 3, 13, 0, lat);
        chk_p("t2_entry_p", 6, 13);
        run_op(6, 1, 13, 0, lat);
        chk_p("t2_exit_p", 5, 13);

        // Largest operands and a zero operand
        run_op(12, 12, 13, 0, lat);
        chk_p("t3_max_p", 3, 13);
        run_op(0, 7, 13, 0, lat);
        chk_p("t3_zero_a_p", 0, 13);
        run_op(9, 0, 13, 0, lat);
        chk_p("t3_zero_b_p", 0, 13);

        // go re-pulsed mid-run is ignored
        run_op(5, 7, 13, 3, lat);
        chk("t4_latency", longint'(lat), LAT);
        chk_p("t4_p", 1, 13);

        // Asynchronous reset mid-LOOP
        @(negedge clk);
        bus.go = 1'b1; bus.a = 8'd12; bus.b = 8'd12; bus.n = 8'd13;
        @(posedge clk); #1; bus.go = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("t5_rst_busy", longint'(bus.busy), 0);
        chk("t5_rst_done", longint'(bus.done), 0);
        chk("t5_rst_p",    longint'(bus.p), 0);
        @(negedge clk); #2; rst_n = 1'b1;
        run_op(5, 7, 13, 0, lat);
        chk("t5_latency", longint'(lat), LAT);
        chk_p("t5_p", 1, 13);

        // Random operands against the scoreboard
        for (int i = 0; i < 1000; i++) begin
            rn = 2 * $urandom_range(1, 63) + 1;
            ra = $urandom_range(0, rn - 1);
            rb = $urandom_range(0, rn - 1);
            run_op(ra, rb, rn, 0, lat);
            chk("rand_latency", longint'(lat), LAT);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
